// File: rtl/times_table_arbiter_pkg.sv
// Shared widths, requester-id encoding and helpers for the times-table arbiter.
package times_table_arbiter_pkg;

    localparam int unsigned OPERAND_W = 3;
    localparam int unsigned PRODUCT_W = 6;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned STAT_W    = 8;

    typedef enum logic {
        ReqId0 = 1'b0,
        ReqId1 = 1'b1
    } req_id_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/times_table_arbiter_rsp_pipe.sv
// Valid/id shift pipeline tracking in-flight ROM reads; synchronous clear drops them all.
module tt_rsp_pipe
    import times_table_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    in_valid,
    input  req_id_e in_id,
    output logic    out_valid,
    output req_id_e out_id
);

    logic [DEPTH-1:0] valid_q;
    req_id_e          id_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i] <= ReqId0;
            end
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_id;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/times_table_arbiter.sv
// Round-robin arbiter sharing a times-table ROM between two requesters.
// Optional grant counters are enabled by defining TT_ARB_STATS_EN.
module times_table_arbiter
    import times_table_arbiter_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [OPERAND_W-1:0] req0_a,
    input  logic [OPERAND_W-1:0] req0_b,
    input  logic                 req1_valid,
    input  logic [OPERAND_W-1:0] req1_a,
    input  logic [OPERAND_W-1:0] req1_b,
    output logic                 req0_ready,
    output logic                 req1_ready,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PRODUCT_W-1:0] rom_data,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [PRODUCT_W-1:0] rsp_data
`ifdef TT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    grant_cnt0,
    output logic [STAT_W-1:0]    grant_cnt1
`endif
);

    req_id_e last_grant_q, last_grant_d;
    logic    grant0, grant1, xfer;
    req_id_e grant_id;
    logic    pipe_valid;
    req_id_e pipe_id;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_grant_q == ReqId1)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        xfer         = grant0 | grant1;
        grant_id     = grant1 ? ReqId1 : ReqId0;
        last_grant_d = xfer ? grant_id : last_grant_q;
        rom_en       = xfer;
        rom_addr     = '0;
        if (grant0) begin
            rom_addr = {req0_a, req0_b};
        end else if (grant1) begin
            rom_addr = {req1_a, req1_b};
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ReqId1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    tt_rsp_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_rsp_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (xfer),
        .in_id     (grant_id),
        .out_valid (pipe_valid),
        .out_id    (pipe_id)
    );

    assign rsp_valid = pipe_valid;
    assign rsp_id    = pipe_valid && (pipe_id == ReqId1);
    assign rsp_data  = pipe_valid ? rom_data : '0;

`ifdef TT_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant0) cnt0_q <= sat_inc(cnt0_q);
            if (grant1) cnt1_q <= sat_inc(cnt1_q);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/times_table_arbiter.md
TIMES_TABLE_ARBITER -- requirements
Module: times_table_arbiter

Interface
REQ-001 Parameter ROM_LATENCY, default 1, SHALL set the cycles from rom_en high to valid rom_data (legal 1..4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n holds an operand pair.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  3 each  multiplicands 0..7.
REQ-006 req0_ready / req1_ready  output  1  requester n is granted this cycle.
REQ-007 rom_en  output  1  times-table ROM read enable; ROM write enable is tied low outside this block.
REQ-008 rom_addr  output  6  ROM address {a,b}.
REQ-009 rom_data  input  6  ROM read data, product a*b.
REQ-010 rsp_valid  output  1  response strobe, one cycle per accepted request.
REQ-011 rsp_id  output  1  requester that owns the response.
REQ-012 rsp_data  output  6  product returned to that requester.

Function
REQ-013 A transfer SHALL occur on requester n when reqn_valid && reqn_ready; at most one transfer per cycle.
REQ-014 reqn_ready SHALL be combinational: high only for the granted requester, and only while its valid is high.
REQ-015 Single valid requester SHALL be granted immediately, with no idle cycle.
REQ-016 Both valid: grant SHALL go to the requester not granted most recently (round-robin), using a 1-bit last_grant register.
REQ-017 last_grant SHALL update only on a transfer.
REQ-018 On a transfer: rom_en=1 and rom_addr={a,b} of the granted requester, same cycle.
REQ-019 No transfer: rom_en=0 and rom_addr=0.
REQ-020 A ROM_LATENCY-deep valid/id shift pipeline SHALL track in-flight reads.
REQ-021 Exactly ROM_LATENCY cycles after a transfer: rsp_valid=1, rsp_id=granted id, rsp_data=rom_data.
REQ-022 rsp_data SHALL be 0 whenever rsp_valid=0.
REQ-023 No response backpressure: full throughput of one request per cycle; responses return in issue order.
REQ-024 Valid dropped without a transfer SHALL NOT alter last_grant or the pipeline.

Reset
REQ-025 rst SHALL clear the pipeline; all in-flight responses are discarded, with no rsp_valid after the reset edge.
REQ-026 Reset values: last_grant=1 (req0 wins the first contention); rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-027 While rst is high: reqn_ready=0 and rom_en=0.

Configuration
REQ-028 Macro TT_ARB_STATS_EN defined: outputs grant_cnt0 and grant_cnt1 (8 bits each) SHALL be present.
REQ-029 Each counter: +1 per transfer of its requester, saturating at 255, cleared by rst.
REQ-030 Macro undefined: these ports and counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the operand width (3), product width (6), address width (6) and requester-id encoding constants.
REQ-032 Sub-module tt_rsp_pipe SHALL implement the ROM_LATENCY valid/id shift pipeline with synchronous clear.

Verification (ROM model returns a*b after ROM_LATENCY)
REQ-033 ROM_LATENCY=1, req0 only, a=3, b=5 -> same cycle req0_ready=1, rom_addr=29; next cycle rsp_valid=1, rsp_id=0, rsp_data=15.
REQ-034 Both valid for 6 cycles after reset -> grants 0,1,0,1,0,1; responses 1 cycle later in the same order with correct products.
REQ-035 ROM_LATENCY=3, req1 a=7, b=7 then a=0, b=4 back-to-back -> rsp_data 49 then 0 on consecutive cycles, 3 cycles after each issue.
REQ-036 rst asserted 1 cycle after a transfer with ROM_LATENCY=2 -> no rsp_valid ever for that request; first contention after reset grants req0.
REQ-037 TT_ARB_STATS_EN, req0 continuously valid for 300 cycles -> grant_cnt0=255 (saturated), grant_cnt1=0.
REQ-038 req1 valid 1 cycle, then dropped while req0 is granted -> no transfer on req1; last_grant and responses unaffected.
